// File: rtl/shared_operator_arbiter_pkg.sv
// Shared types for the operator arbiter: FSM states, operation codes and
// the operation-name constants accepted by the op parameter.
package shared_operator_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_e;

    localparam logic [23:0] OP_NAME_ADD = "add";
    localparam logic [23:0] OP_NAME_SUB = "sub";
    localparam logic [23:0] OP_NAME_MUL = "mul";

    // Never returns less than 1 so single-value fields still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_operator_arbiter_if.sv
// Request/ack bundle between the clients and the shared operator arbiter.
// slave = arbiter side, master = client side.
interface shared_operator_arbiter_if
    import shared_operator_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int IW = clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   ack;
    logic [N*W-1:0] din_a;
    logic [N*W-1:0] din_b;
    logic [W-1:0]   dout;
    logic [IW-1:0]  grant_id;
    logic           busy;

    modport slave (
        input  req, din_a, din_b,
        output ack, dout, grant_id, busy
    );

    modport master (
        output req, din_a, din_b,
        input  ack, dout, grant_id, busy
    );

endinterface

// File: rtl/operator.sv
// Combinational N-input arithmetic unit; folds the inputs left to right
// with the selected operation, keeping the low data_width bits.
module operator
    import shared_operator_arbiter_pkg::*;
#(
    parameter int  input_size = 2,
    parameter int  data_width = 32,
    parameter op_e op_sel     = OP_MUL
) (
    input  logic [input_size*data_width-1:0] din,
    output logic [data_width-1:0]            dout
);

    logic [data_width-1:0] acc;

    always_comb begin
        acc = din[data_width-1:0];
        for (int i = 1; i < input_size; i++) begin
            case (op_sel)
                OP_ADD:  acc = acc + din[i*data_width +: data_width];
                OP_SUB:  acc = acc - din[i*data_width +: data_width];
                OP_MUL:  acc = acc * din[i*data_width +: data_width];
                default: acc = '0;
            endcase
        end
        if (op_sel == OP_NONE) begin
            acc = '0;
        end
        dout = acc;
    end

endmodule

// File: rtl/shared_operator_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_picker
    import shared_operator_arbiter_pkg::*;
#(
    parameter int n  = 4,
    parameter int iw = clog2(n)
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    output logic          found,
    output logic [iw-1:0] win
);

    int idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(ptr) + k) % n;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = iw'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_operator_arbiter.sv
// Time-multiplexes one add/sub/mul unit among num_clients req/ack clients,
// granting round-robin and returning each result with a one-cycle ack.
module shared_operator_arbiter
    import shared_operator_arbiter_pkg::*;
#(
    parameter int num_clients = 4,
    parameter int data_width  = 32,
    parameter     op          = "mul",
    parameter int latency     = 2
) (
    input logic                      clk,
    input logic                      rst,
    shared_operator_arbiter_if.slave bus
);

    localparam int N  = num_clients;
    localparam int W  = data_width;
    localparam int IW = clog2(N);
    localparam int CW = clog2(latency + 1);

    localparam op_e OP_SEL =
        (op == OP_NAME_ADD) ? OP_ADD :
        (op == OP_NAME_SUB) ? OP_SUB :
        (op == OP_NAME_MUL) ? OP_MUL : OP_NONE;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gid_q, gid_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   dout_q, dout_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           busy_q, busy_d;

    logic           found;
    logic [IW-1:0]  win;
    logic [W-1:0]   result;

    rr_picker #(
        .n  (N),
        .iw (IW)
    ) u_pick (
        .req   (bus.req & ~ack_q),
        .ptr   (ptr_q),
        .found (found),
        .win   (win)
    );

    operator #(
        .input_size (2),
        .data_width (W),
        .op_sel     (OP_SEL)
    ) u_op (
        .din  ({opb_q, opa_q}),
        .dout (result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        dout_d  = dout_q;
        ack_d   = ack_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    opa_d   = bus.din_a[int'(win)*W +: W];
                    opb_d   = bus.din_b[int'(win)*W +: W];
                    gid_d   = win;
                    cnt_d   = CW'(latency);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    dout_d  = result;
                    ack_d   = {{(N-1){1'b0}}, 1'b1} << gid_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d   = '0;
                ptr_d   = (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reset aborts any in-flight operation without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            dout_q  <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.dout     = dout_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = busy_q;

endmodule
